// File: rtl/dmem_mmio_if.sv
// dmem_mmio_if: core data-port and GPIO/IRQ signals of the data memory system
interface dmem_mmio_if #(parameter int GPIO_W = 16);
  logic              we;
  logic [31:0]       a;
  logic [31:0]       wd;
  logic [31:0]       rd;
  logic [GPIO_W-1:0] gpio_in;
  logic [GPIO_W-1:0] gpio_out;
  logic              timer_irq;
  modport master (output we, a, wd, gpio_in, input rd, gpio_out, timer_irq);
  modport slave  (input we, a, wd, gpio_in, output rd, gpio_out, timer_irq);
endinterface

// File: rtl/dmem_mmio.sv
// dmem_mmio: data RAM plus a memory-mapped page with GPIO, compare/match timer and cycle counter
module dmem_mmio #(
  parameter int RAM_WORDS = 64,
  parameter int GPIO_W    = 16
) (
  input logic        clk,
  input logic        reset,
  dmem_mmio_if.slave bus
);
  localparam int AW = $clog2(RAM_WORDS);
  logic [31:0]       r_ram [RAM_WORDS];
  logic [GPIO_W-1:0] r_gpio_out, r_sync1, r_sync2;
  logic [31:0]       r_tcnt, r_tcmp, r_cycles;
  logic              r_en, r_autoclr, r_match, r_irq_en;
  logic              w_ram_sel, w_per_sel, w_hit, w_clr_match;
  logic              w_wr_gpio, w_wr_tcnt, w_wr_tcmp, w_wr_tctrl;
  logic [5:0]        w_off;
  logic [AW-1:0]     w_idx;
  logic [31:0]       w_per_rd;

  assign w_ram_sel   = bus.a < 32'(4 * RAM_WORDS);
  assign w_per_sel   = bus.a[31:8] == 24'hFFFFFF;
  assign w_off       = bus.a[7:2];
  assign w_idx       = bus.a[AW+1:2];
  assign w_wr_gpio   = bus.we & w_per_sel & (w_off == 6'd0);
  assign w_wr_tcnt   = bus.we & w_per_sel & (w_off == 6'd2);
  assign w_wr_tcmp   = bus.we & w_per_sel & (w_off == 6'd3);
  assign w_wr_tctrl  = bus.we & w_per_sel & (w_off == 6'd4);
  assign w_hit       = r_en & (r_tcnt == r_tcmp);
  assign w_clr_match = w_wr_tctrl & bus.wd[2];

  // RAM is not reset; a write is dropped only when reset is already high at the edge
  always_ff @(posedge clk)
    if (bus.we && w_ram_sel && !reset) r_ram[w_idx] <= bus.wd;

  // two-flop synchroniser for the external GPIO inputs
  always_ff @(posedge clk or posedge reset)
    if (reset) {r_sync1, r_sync2} <= '0;
    else {r_sync1, r_sync2} <= {bus.gpio_in, r_sync1};

  // software-written registers: GPIO_OUT, TCMP and the R/W TCTRL bits
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_gpio_out <= '0;
      r_tcmp     <= '0;
      {r_irq_en, r_autoclr, r_en} <= '0;
    end else begin
      if (w_wr_gpio) r_gpio_out <= bus.wd[GPIO_W-1:0];
      if (w_wr_tcmp) r_tcmp <= bus.wd;
      if (w_wr_tctrl) {r_irq_en, r_autoclr, r_en} <= {bus.wd[3], bus.wd[1:0]};
    end

  // timer: direct load beats auto-clear beats increment; a fresh match beats write-1-to-clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_tcnt  <= '0;
      r_match <= 1'b0;
    end else begin
      r_tcnt  <= w_wr_tcnt ? bus.wd : (w_hit & r_autoclr) ? '0 : r_en ? r_tcnt + 1 : r_tcnt;
      r_match <= w_hit | (r_match & ~w_clr_match);
    end

  // free-running cycle counter
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cycles <= '0;
    else r_cycles <= r_cycles + 1;

  // combinational read mux for the peripheral page
  always_comb
    w_per_rd = (w_off == 6'd0) ? 32'(r_gpio_out) :
               (w_off == 6'd1) ? 32'(r_sync2) :
               (w_off == 6'd2) ? r_tcnt :
               (w_off == 6'd3) ? r_tcmp :
               (w_off == 6'd4) ? {28'b0, r_irq_en, r_match, r_autoclr, r_en} :
               (w_off == 6'd5) ? r_cycles : 32'b0;

  assign bus.rd        = w_ram_sel ? r_ram[w_idx] : w_per_sel ? w_per_rd : 32'b0;
  assign bus.gpio_out  = r_gpio_out;
  assign bus.timer_irq = r_match & r_irq_en;
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed self-checking bench for dmem_mmio
module tb_dmem_mmio;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  dmem_mmio_if #(.GPIO_W(16)) bus ();
  dmem_mmio #(.RAM_WORDS(64), .GPIO_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.we = 1'b0;
    bus.a  = addr;
    #1;
    chk(tag, bus.rd, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.we = 1'b1;
    bus.a  = addr;
    bus.wd = data;
    step();
    bus.we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1;
    bus.we = 1'b0;
    bus.a = '0;
    bus.wd = '0;
    bus.gpio_in = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_gpio_out", 32'(bus.gpio_out), 32'h0);
    chk("rst_irq", 32'(bus.timer_irq), 32'h0);
    rd_chk("rst_tcnt", 32'hFFFFFF08, 32'h0);
    rd_chk("rst_tcmp", 32'hFFFFFF0C, 32'h0);
    rd_chk("rst_tctrl", 32'hFFFFFF10, 32'h0);
    rd_chk("rst_cycles", 32'hFFFFFF14, 32'h0);
    wr(32'h64, 32'd7);
    rd_chk("ram_64", 32'h64, 32'd7);
    rd_chk("ram_66", 32'h66, 32'd7);
    wr(32'hFFFFFF00, 32'hABCD1234);
    chk("gpio_out", 32'(bus.gpio_out), 32'h1234);
    rd_chk("gpio_out_rd", 32'hFFFFFF00, 32'h00001234);
    bus.gpio_in = 16'h00A5;
    rd_chk("gpio_in_e0", 32'hFFFFFF04, 32'h0);
    step();
    rd_chk("gpio_in_e1", 32'hFFFFFF04, 32'h0);
    step();
    rd_chk("gpio_in_e2", 32'hFFFFFF04, 32'h000000A5);
    wr(32'hFFFFFF0C, 32'd3);
    wr(32'hFFFFFF10, 32'h0B);
    for (int i = 0; i < 6; i++) begin
      rd_chk("tcnt_autoclr", 32'hFFFFFF08, 32'(i % 4));
      chk("irq_autoclr", 32'(bus.timer_irq), (i >= 4) ? 32'd1 : 32'd0);
      if (i == 4) rd_chk("tctrl_match", 32'hFFFFFF10, 32'hF);
      if (i < 5) step();
    end
    wr(32'hFFFFFF10, 32'h0F);
    chk("irq_cleared", 32'(bus.timer_irq), 32'h0);
    rd_chk("tctrl_cleared", 32'hFFFFFF10, 32'hB);
    step();
    rd_chk("tcnt_at_cmp", 32'hFFFFFF08, 32'd3);
    wr(32'hFFFFFF10, 32'h0F);
    chk("irq_set_wins", 32'(bus.timer_irq), 32'h1);
    rd_chk("tctrl_set_wins", 32'hFFFFFF10, 32'hF);
    wr(32'hFFFFFF0C, 32'd5);
    wr(32'hFFFFFF10, 32'h01);
    rd_chk("tctrl_keep_match", 32'hFFFFFF10, 32'h5);
    wr(32'hFFFFFF08, 32'hFFFFFFFE);
    rd_chk("tcnt_load", 32'hFFFFFF08, 32'hFFFFFFFE);
    step();
    rd_chk("tcnt_ffff", 32'hFFFFFF08, 32'hFFFFFFFF);
    step();
    rd_chk("tcnt_wrap", 32'hFFFFFF08, 32'h0);
    wr(32'h0, 32'h11);
    wr(32'h00001000, 32'h55);
    wr(32'hFFFFFF20, 32'h55);
    rd_chk("unmap_1000", 32'h00001000, 32'h0);
    rd_chk("unmap_ff20", 32'hFFFFFF20, 32'h0);
    rd_chk("unmap_ram0", 32'h0, 32'h11);
    rd_chk("unmap_ram64", 32'h64, 32'd7);
    rd_chk("unmap_gpio", 32'hFFFFFF00, 32'h1234);
    rd_chk("unmap_tctrl", 32'hFFFFFF10, 32'h5);
    bus.a = 32'hFFFFFF14;
    #1;
    n = 0;
    while (bus.rd !== 32'd50 && n < 100) begin
      step();
      n++;
    end
    chk("cycles_50", bus.rd, 32'd50);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_gpio_out", 32'(bus.gpio_out), 32'h0);
    chk("mid_irq", 32'(bus.timer_irq), 32'h0);
    rd_chk("mid_gpio_rd", 32'hFFFFFF00, 32'h0);
    rd_chk("mid_gpio_in", 32'hFFFFFF04, 32'h0);
    rd_chk("mid_tcnt", 32'hFFFFFF08, 32'h0);
    rd_chk("mid_tcmp", 32'hFFFFFF0C, 32'h0);
    rd_chk("mid_tctrl", 32'hFFFFFF10, 32'h0);
    rd_chk("mid_cycles", 32'hFFFFFF14, 32'h0);
    rd_chk("mid_ram64", 32'h64, 32'd7);
    step();
    reset = 1'b0;
    rd_chk("post_cycles0", 32'hFFFFFF14, 32'h0);
    step();
    rd_chk("post_cycles1", 32'hFFFFFF14, 32'h1);
    rd_chk("post_ram64", 32'h64, 32'd7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
